// File: rtl/ota_pkg.sv
// Shared types and constants for the OTA trim controller: FSM states,
// pad status bit positions and default channel geometry.
package ota_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2
  } ota_state_e;

  localparam int UIO_BUSY_BIT = 0;
  localparam int UIO_DONE_BIT = 1;
  localparam int UIO_ERR_BIT  = 2;

  localparam int N_CH_DEF   = 4;
  localparam int TRIM_W_DEF = 6;

endpackage

// File: rtl/ota_shift_reg.sv
// Serial shadow register for trim codes: MSB-first shift-in, parallel load
// for readback, and a saturating count of bits received since the last commit.
module ota_shift_reg
  import ota_pkg::*;
#(
  parameter int WIDTH = N_CH_DEF * TRIM_W_DEF,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             shift_bit,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_data,
  input  logic             clear_cnt,
  output logic [WIDTH-1:0] shadow,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  assign full = (bit_cnt == CNT_FULL);

  // Shadow data and bit count; a commit clears only the count, the data stays for readback
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      bit_cnt <= '0;
    end else if (clear_cnt) begin
      bit_cnt <= '0;
    end else if (load_en) begin
      shadow  <= load_data;
      bit_cnt <= CNT_FULL;
    end else if (shift_en) begin
      shadow <= {shadow[WIDTH-2:0], shift_bit};
      if (!full) begin
        bit_cnt <= bit_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/ota_trim_ctrl.sv
// OTA trim controller: serial shadow loading, checked commit to the active trim
// codes, then a fixed settle wait reported through busy/done and pad status.
module ota_trim_ctrl
  import ota_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int TRIM_W     = TRIM_W_DEF,
  parameter int SETTLE_CYC = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ena,
  input  logic                     sh_strobe,
  input  logic                     sh_data,
  input  logic                     ld_strobe,
  input  logic                     rd_strobe,
  output logic                     sh_out,
  output logic [N_CH*TRIM_W-1:0]   trim_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [7:0]               uio_out,
  output logic [7:0]               uio_oe
);

  localparam int WIDTH  = N_CH * TRIM_W;
  localparam int BCNT_W = $clog2(WIDTH + 1);
  localparam int SCNT_W = $clog2(SETTLE_CYC + 1);
  localparam logic [SCNT_W-1:0] SETTLE_LOAD = SCNT_W'(SETTLE_CYC - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE    = SCNT_W'(1);

  ota_state_e        state;
  ota_state_e        next_state;
  logic [SCNT_W-1:0] settle_cnt;
  logic [WIDTH-1:0]  shadow;
  logic [BCNT_W-1:0] bit_cnt;
  logic              full;
  logic              do_commit;
  logic              do_reject;
  logic              do_rd;
  logic              do_sh;
  logic              busy_nxt;
  logic              done_nxt;
  logic              err_nxt;

  ota_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (do_sh),
    .shift_bit (sh_data),
    .load_en   (do_rd),
    .load_data (trim_out),
    .clear_cnt (state == APPLY),
    .shadow    (shadow),
    .bit_cnt   (bit_cnt),
    .full      (full)
  );

  // Strobe decode: only honoured in IDLE with ena high, priority ld > rd > sh
  always_comb begin
    do_commit = 1'b0;
    do_reject = 1'b0;
    do_rd     = 1'b0;
    do_sh     = 1'b0;
    if ((state == IDLE) && ena) begin
      if (ld_strobe) begin
        do_commit = full;
        do_reject = !full;
      end else if (rd_strobe) begin
        do_rd = 1'b1;
      end else begin
        do_sh = sh_strobe;
      end
    end else begin
      do_commit = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = do_commit ? APPLY : IDLE;
      APPLY:   next_state = SETTLE;
      SETTLE:  next_state = (settle_cnt == '0) ? IDLE : SETTLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode, computed one cycle ahead so the flags come straight from flops
  always_comb begin
    busy_nxt = (next_state == APPLY) || (next_state == SETTLE);
    done_nxt = (state == SETTLE) && (next_state == IDLE);
    if (do_commit) begin
      err_nxt = 1'b0;
    end else if (do_reject) begin
      err_nxt = 1'b1;
    end else begin
      err_nxt = err;
    end
  end

  // Status flags, active trim codes and settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      trim_out   <= '0;
      settle_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      done <= done_nxt;
      err  <= err_nxt;
      if (state == APPLY) begin
        trim_out   <= shadow;
        settle_cnt <= SETTLE_LOAD;
      end else if ((state == SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - SCNT_ONE;
      end
    end
  end

  assign sh_out = shadow[WIDTH-1];

  always_comb begin
    uio_out               = 8'h00;
    uio_out[UIO_BUSY_BIT] = busy;
    uio_out[UIO_DONE_BIT] = done;
    uio_out[UIO_ERR_BIT]  = err;
    uio_oe                = {5'b00000, {3{ena}}};
  end

endmodule

// File: tb/tb_ota_trim_ctrl.sv
// Directed bench for ota_trim_ctrl: commits are scored by a done-driven monitor
// against a queue of expected trim codes and done cycles.
module tb_ota_trim_ctrl;
  import ota_pkg::*;

  localparam int N_CH       = 4;
  localparam int TRIM_W     = 6;
  localparam int SETTLE_CYC = 16;
  localparam int W          = N_CH * TRIM_W;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic         sh_strobe = 1'b0;
  logic         sh_data = 1'b0;
  logic         ld_strobe = 1'b0;
  logic         rd_strobe = 1'b0;
  logic         sh_out;
  logic [W-1:0] trim_out;
  logic         busy;
  logic         done;
  logic         err;
  logic [7:0]   uio_out;
  logic [7:0]   uio_oe;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] trim;
    int           at_cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  ota_trim_ctrl #(.N_CH(N_CH), .TRIM_W(TRIM_W), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk       (clk),
    .rst       (rst),
    .ena       (ena),
    .sh_strobe (sh_strobe),
    .sh_data   (sh_data),
    .ld_strobe (ld_strobe),
    .rd_strobe (rd_strobe),
    .sh_out    (sh_out),
    .trim_out  (trim_out),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding commit
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
      end else begin
        mon_e = sb.pop_front();
        check("done_trim", 32'(trim_out), 32'(mon_e.trim));
        check("done_latency", 32'(cyc), 32'(mon_e.at_cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic shift_word(input logic [W-1:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      sh_data   = v[i];
      sh_strobe = 1'b1;
      tick();
    end
    sh_strobe = 1'b0;
    sh_data   = 1'b0;
  endtask

  // Commit, wait out busy (optionally with strobe noise or ena dropped mid-settle)
  task automatic commit(input logic [W-1:0] exp, input bit noise, input bit drop_ena);
    int   n = 0;
    exp_t e;
    ld_strobe = 1'b1;
    e.trim    = exp;
    e.at_cyc  = cyc + SETTLE_CYC + 2;
    sb.push_back(e);
    tick();
    ld_strobe = 1'b0;
    check("commit_err_clear", 32'(err), 32'd0);
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (drop_ena && n == 4) ena = 1'b0;
      sh_strobe = noise;
      ld_strobe = noise;
      rd_strobe = noise;
      sh_data   = noise;
      tick();
    end
    sh_strobe = 1'b0;
    ld_strobe = 1'b0;
    rd_strobe = 1'b0;
    sh_data   = 1'b0;
    ena       = 1'b1;
    check("busy_cycles", 32'(n), 32'(SETTLE_CYC + 1));
    check("trim_after_commit", 32'(trim_out), 32'(exp));
    check("err_after_commit", 32'(err), 32'd0);
  endtask

  initial begin
    logic [W-1:0] rb;
    logic [W-1:0] v38;
    int           n_done;

    // Reset state
    tick(); tick();
    check("rst_trim", 32'(trim_out), 32'd0);
    check("rst_flags", {29'd0, err, done, busy}, 32'd0);
    check("rst_sh_out", 32'(sh_out), 32'd0);
    check("rst_uio_oe", 32'(uio_oe), 32'h07);
    rst = 1'b0;
    tick();

    // Full 24-bit load and commit
    shift_word(24'hA5C3F1, 24);
    commit(24'hA5C3F1, 1'b0, 1'b0);

    // Short load: rejected commit, sticky err, no busy
    shift_word(24'h0002AD, 10);
    ld_strobe = 1'b1;
    tick();
    ld_strobe = 1'b0;
    check("short_err", 32'(err), 32'd1);
    check("short_uio_err", 32'(uio_out), 32'h04);
    n_done = 0;
    repeat (4) begin
      if (busy !== 1'b0) n_done++;
      tick();
    end
    check("short_no_busy", 32'(n_done), 32'd0);
    check("short_trim_kept", 32'(trim_out), 32'hA5C3F1);
    check("short_err_sticky", 32'(err), 32'd1);
    shift_word(24'h123456, 24);
    commit(24'h123456, 1'b0, 1'b0);

    // Readback via rd_strobe then serial shift-out, MSB first
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      rb[i]     = sh_out;
      sh_data   = 1'b0;
      sh_strobe = 1'b1;
      tick();
    end
    sh_strobe = 1'b0;
    check("readback", 32'(rb), 32'h123456);

    // Commit with strobe noise during APPLY/SETTLE, which must be ignored
    shift_word(24'h0F0F0F, 24);
    commit(24'h0F0F0F, 1'b1, 1'b0);

    // Simultaneous sh+ld at 23 bits: ld wins, shift dropped
    v38 = 24'h6B2D17;
    shift_word(v38 >> 1, 23);
    sh_data   = 1'b1;
    sh_strobe = 1'b1;
    ld_strobe = 1'b1;
    tick();
    sh_strobe = 1'b0;
    ld_strobe = 1'b0;
    sh_data   = 1'b0;
    check("simul_err", 32'(err), 32'd1);
    check("simul_bit_cnt", 32'(dut.u_sr.bit_cnt), 32'd23);
    check("simul_trim_kept", 32'(trim_out), 32'h0F0F0F);
    check("simul_busy", 32'(busy), 32'd0);
    shift_word(v38, 1);
    commit(24'h6B2D17, 1'b0, 1'b0);

    // Reset on the 5th SETTLE cycle
    shift_word(24'h55AA33, 24);
    ld_strobe = 1'b1;
    tick();
    ld_strobe = 1'b0;
    repeat (5) tick();
    check("settle5_busy", 32'(busy), 32'd1);
    check("settle5_state", 32'(dut.state), 32'(SETTLE));
    rst = 1'b1;
    tick();
    check("midrst_state", 32'(dut.state), 32'(IDLE));
    check("midrst_trim", 32'(trim_out), 32'd0);
    check("midrst_flags", {29'd0, err, done, busy}, 32'd0);
    check("midrst_sh_out", 32'(sh_out), 32'd0);
    check("midrst_uio_out", 32'(uio_out), 32'd0);
    rst = 1'b0;
    n_done = 0;
    repeat (30) begin
      tick();
      if (done === 1'b1) n_done++;
    end
    check("midrst_no_done", 32'(n_done), 32'd0);

    // ena low: every strobe ignored, pads released
    shift_word(24'h800000, 24);
    check("ena_sh_out_pre", 32'(sh_out), 32'd1);
    ena = 1'b0;
    tick();
    check("ena0_uio_oe", 32'(uio_oe), 32'h00);
    sh_strobe = 1'b1; tick(); sh_strobe = 1'b0;
    rd_strobe = 1'b1; tick(); rd_strobe = 1'b0;
    ld_strobe = 1'b1; tick(); ld_strobe = 1'b0;
    sh_strobe = 1'b1; rd_strobe = 1'b1; ld_strobe = 1'b1;
    tick();
    sh_strobe = 1'b0; rd_strobe = 1'b0; ld_strobe = 1'b0;
    tick();
    check("ena0_sh_out", 32'(sh_out), 32'd1);
    check("ena0_flags", {29'd0, err, done, busy}, 32'd0);
    check("ena0_trim", 32'(trim_out), 32'd0);
    check("ena0_bit_cnt", 32'(dut.u_sr.bit_cnt), 32'd24);
    ena = 1'b1;
    tick();
    check("ena1_uio_oe", 32'(uio_oe), 32'h07);

    // Commit with ena dropped mid-SETTLE: sequence still completes
    commit(24'h800000, 1'b0, 1'b1);

    repeat (5) tick();
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
